// File: rtl/fetch_pc_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_pc_unit
// Description : Program counter and instruction-fetch stage. Fetches one
//               instruction per step over a req/ready memory handshake and
//               presents it to decode for a single execute cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        PCSrc,
  input  logic        JumpTargetSel,
  input  logic        done,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam int unsigned     c_cnt_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_zero = c_cnt_w'(0);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_exec  = 2'd1;
  localparam logic [1:0] c_st_halt  = 2'd2;

  localparam logic [1:0] c_fault_none     = 2'b00;
  localparam logic [1:0] c_fault_misalign = 2'b01;
  localparam logic [1:0] c_fault_timeout  = 2'b10;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic [1:0]         r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_fault;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jalr_target;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_unused;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = r_pc + ImmExt;
  assign w_jalr_target   = {ALUResult[31:1], 1'b0};
  assign w_target        = JumpTargetSel ? w_jalr_target : w_branch_target;
  // Only a word-aligned target is fetchable; bit 0 is always cleared for jalr
  // and branch immediates are even, so bit 1 alone signals misalignment.
  assign w_misaligned    = w_target[1];
  assign w_unused        = ALUResult[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_fetch;
      r_pc    <= RESET_PC;
      r_instr <= c_nop;
      r_cnt   <= c_cnt_zero;
      r_fault <= c_fault_none;
    end else begin
      case (r_state)
        c_st_fetch: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_cnt   <= c_cnt_zero;
            r_state <= c_st_exec;
          end else if (r_cnt == c_cnt_last) begin
            r_fault <= c_fault_timeout;
            r_state <= c_st_halt;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_st_exec: begin
          if (done) begin
            r_state <= c_st_halt;
          end else if (!PCSrc) begin
            r_pc    <= w_pc_plus4;
            r_state <= c_st_fetch;
          end else if (w_misaligned) begin
            r_fault <= c_fault_misalign;
            r_state <= c_st_halt;
          end else begin
            r_pc    <= w_target;
            r_state <= c_st_fetch;
          end
        end
        c_st_halt: begin
          r_state <= c_st_halt;
        end
        default: begin
          r_state <= c_st_halt;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == c_st_fetch);
  assign instr_valid = (r_state == c_st_exec);
  assign halted      = (r_state == c_st_halt);
  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign instr       = r_instr;
  assign fault       = r_fault;

endmodule
`default_nettype wire
